// File: rtl/mem_pkg.sv
// Shared constants and types for the memory library (flip-flops, latches, register files, RAMs).
package mem_pkg;

  localparam int DEFAULT_WIDTH   = 1;
  localparam int CLK_HALF_PERIOD = 5;

  typedef logic [DEFAULT_WIDTH-1:0] data_t;

endpackage : mem_pkg

// File: rtl/dff.sv
// Parameterised rising-edge D flip-flop with asynchronous active-low reset to RESET_VALUE.
// Optional clock enable port `ce` is added when DFF_CE_EN is defined.
module dff
  import mem_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] in,
  input  logic             clk,
  input  logic             rst_n
`ifdef DFF_CE_EN
  ,
  input  logic             ce
`endif
);

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  // Next-state select: capture on every edge, or only when enabled.
  always_comb begin
    out_d = out_q;
`ifdef DFF_CE_EN
    if (ce == 1'b1) begin
      out_d = in;
    end else begin
      out_d = out_q;
    end
`else
    out_d = in;
`endif
  end

  // State register; reset wins over clock and enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= RESET_VALUE;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule : dff

// File: tb/tb_dff.sv
// Self-checking bench for dff: directed timeline checks followed by randomized stimulus
// against a reference model. Contains the simulation-only common_clock source.
module common_clock
  import mem_pkg::*;
#(
  parameter int HALF_PERIOD = CLK_HALF_PERIOD
) (
  output logic clk
);
  initial begin
    clk = 1'b0;
    forever #(HALF_PERIOD) clk = ~clk;
  end
endmodule : common_clock

module tb_dff;
  import mem_pkg::*;

  logic       clk;
  logic       rst_n;
  data_t      in1;
  data_t      out1;
  logic [7:0] in8;
  logic [7:0] out8;
  logic       ce;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [7:0] RV8 = 8'hA5;

  common_clock #(.HALF_PERIOD(CLK_HALF_PERIOD)) u_clk (.clk(clk));

  dff u_dut1 (
    .out  (out1),
    .in   (in1),
    .clk  (clk),
    .rst_n(rst_n)
`ifdef DFF_CE_EN
    ,
    .ce   (ce)
`endif
  );

  dff #(.WIDTH(8), .RESET_VALUE(RV8)) u_dut8 (
    .out  (out8),
    .in   (in8),
    .clk  (clk),
    .rst_n(rst_n)
`ifdef DFF_CE_EN
    ,
    .ce   (ce)
`endif
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic wait_until(input longint t);
    if (longint'($time) < t) #(t - longint'($time));
  endtask

  // Reference model: the value each register should currently hold.
  logic       exp1;
  logic [7:0] exp8;
  logic       cap;

  initial begin
    ce    = 1'b1;
    rst_n = 1'b0;
    in1   = 1'b1;
    in8   = 8'h3C;

    wait_until(6);
    check("rst_hold_w1", {7'd0, out1}, 8'h00);
    check("rst_hold_w8", out8, RV8);
    wait_until(7);
    rst_n = 1'b1;
    wait_until(8);
    check("release_no_edge_w1", {7'd0, out1}, 8'h00);
    check("release_no_edge_w8", out8, RV8);
    wait_until(16);
    check("first_capture_w1", {7'd0, out1}, 8'h01);
    check("first_capture_w8", out8, 8'h3C);

    wait_until(20);
    in1 = 1'b0;
    in8 = 8'h5A;
    wait_until(23);
    check("hold_mid_cycle_w1", {7'd0, out1}, 8'h01);
    check("hold_mid_cycle_w8", out8, 8'h3C);
    wait_until(26);
    check("capture_zero_w1", {7'd0, out1}, 8'h00);
    check("capture_w8", out8, 8'h5A);

    wait_until(40);
    in1 = 1'b1;
    wait_until(43);
    check("low_phase_pulse_w1", {7'd0, out1}, 8'h00);
    wait_until(44);
    in1 = 1'b0;
    wait_until(46);
    check("pulse_not_captured_w1", {7'd0, out1}, 8'h00);

    wait_until(50);
    in1 = 1'b1;
    in8 = 8'hC3;
    wait_until(56);
    check("set_one_w1", {7'd0, out1}, 8'h01);
    check("set_w8", out8, 8'hC3);
    wait_until(63);
    rst_n = 1'b0;
    wait_until(64);
    check("async_clear_w1", {7'd0, out1}, 8'h00);
    check("async_clear_w8", out8, RV8);
    rst_n = 1'b1;
    wait_until(65);
    #1;
    check("recapture_w1", {7'd0, out1}, 8'h01);
    check("recapture_w8", out8, 8'hC3);
    exp1 = 1'b1;
    exp8 = 8'hC3;

`ifdef DFF_CE_EN
    wait_until(70);
    ce  = 1'b0;
    in1 = 1'b0;
    in8 = 8'h11;
    wait_until(76);
    check("ce_off_edge1_w1", {7'd0, out1}, 8'h01);
    check("ce_off_edge1_w8", out8, 8'hC3);
    wait_until(86);
    check("ce_off_edge2_w1", {7'd0, out1}, 8'h01);
    check("ce_off_edge2_w8", out8, 8'hC3);
    wait_until(90);
    ce = 1'b1;
    wait_until(96);
    check("ce_on_w1", {7'd0, out1}, 8'h00);
    check("ce_on_w8", out8, 8'h11);
    exp1 = 1'b0;
    exp8 = 8'h11;
`endif

    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        #1;
        rst_n = 1'b0;
        #1;
        exp1 = 1'b0;
        exp8 = RV8;
        check("rand_async_rst_w1", {7'd0, out1}, {7'd0, exp1});
        check("rand_async_rst_w8", out8, exp8);
        rst_n = 1'b1;
      end
      in1 = 1'($urandom);
      in8 = 8'($urandom);
`ifdef DFF_CE_EN
      ce = ($urandom_range(0, 3) != 0);
`endif
      #1;
      check("rand_hold_low_w1", {7'd0, out1}, {7'd0, exp1});
      check("rand_hold_low_w8", out8, exp8);
      @(posedge clk);
      cap = ce;
`ifndef DFF_CE_EN
      cap = 1'b1;
`endif
      if (cap) begin
        exp1 = in1;
        exp8 = in8;
      end
      #1;
      check("rand_capture_w1", {7'd0, out1}, {7'd0, exp1});
      check("rand_capture_w8", out8, exp8);
      #2;
      in1 = ~in1;
      in8 = 8'($urandom);
      #1;
      check("rand_hold_high_w1", {7'd0, out1}, {7'd0, exp1});
      check("rand_hold_high_w8", out8, exp8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t, expected end before 50000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_dff
